// File: rtl/ac_feed_pkg.sv
// Shared types and widths for the Aho-Corasick byte feeder.
package ac_feed_pkg;
  localparam int BYTE_W  = 8;
  localparam int ENTRY_W = BYTE_W + 1;
  localparam int GAP_W   = 4;

  typedef enum logic [1:0] {IDLE, FEED, GAP} feed_state_t;
endpackage

// File: rtl/ac_sync_fifo.sv
// Single-clock fall-through FIFO; dout always shows the head entry.
module ac_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 9
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  // A full FIFO refuses pushes even when a pop frees a slot this cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/ac_byte_feeder.sv
// Buffers a text byte stream and sequences the matcher's EN / INITIALIZE protocol.
module ac_byte_feeder
  import ac_feed_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int GAP_CYCLES = 1,
  parameter int CNT_W      = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_VALID,
  input  logic [BYTE_W-1:0] IN_DATA,
  input  logic              IN_LAST,
  output logic              IN_READY,
  input  logic              HOLD,
  output logic              EN,
  output logic              INITIALIZE,
  output logic [BYTE_W-1:0] STRING,
  output logic              BUSY,
  output logic              STREAM_DONE,
  output logic [CNT_W-1:0]  BYTE_COUNT
);
  feed_state_t        state;
  logic [GAP_W-1:0]   gap_cnt;
  logic [ENTRY_W-1:0] head;
  logic               full;
  logic               empty;
  logic               issue;
  logic               gap_last;
  logic               pop;
  logic               last_flag;
  logic               restart;

  assign IN_READY = !full && !RST;
  assign issue    = !empty && !HOLD;
  assign gap_last = (state == GAP) && (gap_cnt == '0);
  // The last byte's gap always returns to IDLE so STREAM_DONE gets its own cycle.
  assign pop      = issue && ((state == IDLE) || (gap_last && !last_flag));
  assign BUSY     = (state != IDLE) || !empty;

  ac_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (IN_VALID && IN_READY),
    .pop   (pop),
    .din   ({IN_LAST, IN_DATA}),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      gap_cnt     <= '0;
      EN          <= 1'b0;
      INITIALIZE  <= 1'b0;
      STRING      <= '0;
      STREAM_DONE <= 1'b0;
      BYTE_COUNT  <= '0;
      last_flag   <= 1'b0;
      restart     <= 1'b0;
    end else begin
      EN          <= 1'b0;
      STREAM_DONE <= 1'b0;
      if (pop) begin
        state      <= FEED;
        EN         <= 1'b1;
        INITIALIZE <= 1'b0;
        STRING     <= head[BYTE_W-1:0];
        last_flag  <= head[BYTE_W];
        restart    <= 1'b0;
        // A new stream restarts the count; otherwise saturate at all-ones.
        if (restart)          BYTE_COUNT <= CNT_W'(1);
        else if (!(&BYTE_COUNT)) BYTE_COUNT <= BYTE_COUNT + 1'b1;
      end else begin
        case (state)
          FEED: begin
            state      <= GAP;
            INITIALIZE <= 1'b1;
            gap_cnt    <= GAP_W'(GAP_CYCLES - 1);
          end
          GAP: begin
            if (gap_cnt == '0) begin
              state      <= IDLE;
              INITIALIZE <= 1'b0;
              if (last_flag) begin
                STREAM_DONE <= 1'b1;
                restart     <= 1'b1;
              end
            end else begin
              gap_cnt <= gap_cnt - 1'b1;
            end
          end
          default: INITIALIZE <= 1'b0;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ac_byte_feeder.sv
// Directed bench for ac_byte_feeder with default parameters (depth 16, one gap cycle).
module tb_ac_byte_feeder;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        IN_VALID = 1'b0;
  logic [7:0]  IN_DATA = 8'h00;
  logic        IN_LAST = 1'b0;
  logic        IN_READY;
  logic        HOLD = 1'b0;
  logic        EN;
  logic        INITIALIZE;
  logic [7:0]  STRING;
  logic        BUSY;
  logic        STREAM_DONE;
  logic [15:0] BYTE_COUNT;

  int checks = 0;
  int failures = 0;

  ac_byte_feeder dut (
    .CLK         (CLK),
    .RST         (RST),
    .IN_VALID    (IN_VALID),
    .IN_DATA     (IN_DATA),
    .IN_LAST     (IN_LAST),
    .IN_READY    (IN_READY),
    .HOLD        (HOLD),
    .EN          (EN),
    .INITIALIZE  (INITIALIZE),
    .STRING      (STRING),
    .BUSY        (BUSY),
    .STREAM_DONE (STREAM_DONE),
    .BYTE_COUNT  (BYTE_COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; IN_VALID = 1'b1; IN_DATA = 8'hAA; IN_LAST = 1'b0;
    step(); step();
    checks++; if (EN !== 1'b0) begin failures++; $display("FAIL reset_en got=%b want=0", EN); end
    checks++; if (INITIALIZE !== 1'b0) begin failures++; $display("FAIL reset_init got=%b want=0", INITIALIZE); end
    checks++; if (STRING !== 8'h00) begin failures++; $display("FAIL reset_string got=%h want=00", STRING); end
    checks++; if (IN_READY !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b want=0", IN_READY); end
    checks++; if (BYTE_COUNT !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d want=0", BYTE_COUNT); end
    checks++; if (BUSY !== 1'b0 || STREAM_DONE !== 1'b0) begin failures++; $display("FAIL reset_busy_done got=%b%b want=00", BUSY, STREAM_DONE); end
    IN_VALID = 1'b0;
    RST = 1'b0;
    step();
    checks++; if (IN_READY !== 1'b1) begin failures++; $display("FAIL release_ready got=%b want=1", IN_READY); end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL release_empty busy got=%b want=0", BUSY); end
  endtask

  task automatic test_single();
    IN_VALID = 1'b1; IN_DATA = 8'h61; IN_LAST = 1'b1;
    step();
    IN_VALID = 1'b0; IN_LAST = 1'b0;
    checks++; if (EN !== 1'b0) begin failures++; $display("FAIL single_push_en got=%b want=0", EN); end
    step();
    checks++; if (EN !== 1'b1 || STRING !== 8'h61 || INITIALIZE !== 1'b0) begin failures++; $display("FAIL single_feed en=%b str=%h init=%b want 1/61/0", EN, STRING, INITIALIZE); end
    step();
    checks++; if (EN !== 1'b0 || INITIALIZE !== 1'b1 || STRING !== 8'h61) begin failures++; $display("FAIL single_gap en=%b init=%b str=%h want 0/1/61", EN, INITIALIZE, STRING); end
    step();
    checks++; if (STREAM_DONE !== 1'b1 || INITIALIZE !== 1'b0) begin failures++; $display("FAIL single_done done=%b init=%b want 1/0", STREAM_DONE, INITIALIZE); end
    checks++; if (BYTE_COUNT !== 16'd1 || BUSY !== 1'b0) begin failures++; $display("FAIL single_count cnt=%0d busy=%b want 1/0", BYTE_COUNT, BUSY); end
    step();
    checks++; if (STREAM_DONE !== 1'b0 || BYTE_COUNT !== 16'd1) begin failures++; $display("FAIL single_after done=%b cnt=%0d want 0/1", STREAM_DONE, BYTE_COUNT); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [9];
    int idx = 0;
    int last_cyc = -10;
    int dones = 0;
    bytes = '{8'h75, 8'h73, 8'h68, 8'h65, 8'h72, 8'h73, 8'h41, 8'h42, 8'h43};
    for (int c = 0; c < 40; c++) begin
      if (c < 9) begin
        IN_VALID = 1'b1; IN_DATA = bytes[c]; IN_LAST = (c == 8);
      end else begin
        IN_VALID = 1'b0; IN_LAST = 1'b0;
      end
      step();
      if (EN) begin
        checks++;
        if (idx >= 9) begin failures++; $display("FAIL burst_extra_en str=%h want none", STRING); end
        else if (STRING !== bytes[idx]) begin failures++; $display("FAIL burst_order[%0d] got=%h want=%h", idx, STRING, bytes[idx]); end
        if (idx > 0) begin
          checks++;
          if (c - last_cyc != 2) begin failures++; $display("FAIL burst_spacing[%0d] got=%0d want=2", idx, c - last_cyc); end
        end
        last_cyc = c;
        idx++;
      end else if (idx > 0 && idx < 9) begin
        checks++;
        if (INITIALIZE !== 1'b1) begin failures++; $display("FAIL burst_init_between[%0d] got=%b want=1", idx, INITIALIZE); end
      end
      if (EN && INITIALIZE) begin failures++; $display("FAIL burst_en_init_overlap cycle=%0d", c); end
      if (STREAM_DONE) dones++;
    end
    checks++; if (idx != 9) begin failures++; $display("FAIL burst_pulses got=%0d want=9", idx); end
    checks++; if (dones != 1) begin failures++; $display("FAIL burst_done got=%0d want=1", dones); end
    checks++; if (BYTE_COUNT !== 16'd9 || BUSY !== 1'b0) begin failures++; $display("FAIL burst_count cnt=%0d busy=%b want 9/0", BYTE_COUNT, BUSY); end
  endtask

  task automatic test_full_fifo();
    int idx = 0;
    int dones = 0;
    logic pend;
    logic acc;
    HOLD = 1'b1;
    for (int c = 0; c < 16; c++) begin
      IN_VALID = 1'b1; IN_DATA = 8'(c); IN_LAST = 1'b0;
      step();
    end
    checks++; if (IN_READY !== 1'b0) begin failures++; $display("FAIL full_ready got=%b want=0", IN_READY); end
    IN_DATA = 8'h10; IN_LAST = 1'b1;
    step(); step(); step();
    checks++; if (IN_READY !== 1'b0 || EN !== 1'b0 || BUSY !== 1'b1) begin failures++; $display("FAIL full_hold ready=%b en=%b busy=%b want 0/0/1", IN_READY, EN, BUSY); end
    HOLD = 1'b0;
    pend = 1'b1;
    acc = 1'b0;
    for (int c = 0; c < 80; c++) begin
      if (pend && IN_READY) begin
        acc = 1'b1;
        checks++;
        if (idx < 1) begin failures++; $display("FAIL full_accept_before_pop pops=%0d want>=1", idx); end
      end
      step();
      if (acc) begin
        pend = 1'b0; acc = 1'b0; IN_VALID = 1'b0; IN_LAST = 1'b0;
      end
      if (EN) begin
        checks++;
        if (STRING !== 8'(idx)) begin failures++; $display("FAIL full_order[%0d] got=%h want=%h", idx, STRING, 8'(idx)); end
        idx++;
      end
      if (STREAM_DONE) dones++;
    end
    checks++; if (idx != 17) begin failures++; $display("FAIL full_pulses got=%0d want=17", idx); end
    checks++; if (dones != 1 || BYTE_COUNT !== 16'd17) begin failures++; $display("FAIL full_done dones=%0d cnt=%0d want 1/17", dones, BYTE_COUNT); end
  endtask

  task automatic test_hold_mid();
    IN_VALID = 1'b1; IN_DATA = 8'h31; IN_LAST = 1'b0;
    step();
    IN_DATA = 8'h32;
    step();
    checks++; if (EN !== 1'b1 || STRING !== 8'h31) begin failures++; $display("FAIL hold_first en=%b str=%h want 1/31", EN, STRING); end
    IN_DATA = 8'h33; IN_LAST = 1'b1;
    step();
    IN_VALID = 1'b0; IN_LAST = 1'b0;
    checks++; if (INITIALIZE !== 1'b1) begin failures++; $display("FAIL hold_in_gap init=%b want=1", INITIALIZE); end
    HOLD = 1'b1;
    step();
    checks++; if (EN !== 1'b0 || INITIALIZE !== 1'b0 || BUSY !== 1'b1) begin failures++; $display("FAIL hold_paused en=%b init=%b busy=%b want 0/0/1", EN, INITIALIZE, BUSY); end
    step();
    checks++; if (EN !== 1'b0) begin failures++; $display("FAIL hold_still en=%b want=0", EN); end
    HOLD = 1'b0;
    step();
    checks++; if (EN !== 1'b1 || STRING !== 8'h32) begin failures++; $display("FAIL hold_resume en=%b str=%h want 1/32", EN, STRING); end
    step();
    step();
    checks++; if (EN !== 1'b1 || STRING !== 8'h33) begin failures++; $display("FAIL hold_third en=%b str=%h want 1/33", EN, STRING); end
    step();
    step();
    checks++; if (STREAM_DONE !== 1'b1 || BYTE_COUNT !== 16'd3) begin failures++; $display("FAIL hold_done done=%b cnt=%0d want 1/3", STREAM_DONE, BYTE_COUNT); end
  endtask

  task automatic test_reset_mid_feed();
    int bad = 0;
    HOLD = 1'b1;
    for (int c = 0; c < 6; c++) begin
      IN_VALID = 1'b1; IN_DATA = 8'hC0 + 8'(c); IN_LAST = (c == 5);
      step();
    end
    IN_VALID = 1'b0; IN_LAST = 1'b0;
    HOLD = 1'b0;
    step();
    checks++; if (EN !== 1'b1 || STRING !== 8'hC0) begin failures++; $display("FAIL rstmid_feed en=%b str=%h want 1/c0", EN, STRING); end
    #2;
    RST = 1'b1;
    #1;
    checks++; if (EN !== 1'b0 || INITIALIZE !== 1'b0 || STRING !== 8'h00) begin failures++; $display("FAIL rstmid_async en=%b init=%b str=%h want 0/0/00", EN, INITIALIZE, STRING); end
    checks++; if (IN_READY !== 1'b0 || BYTE_COUNT !== 16'd0) begin failures++; $display("FAIL rstmid_ctrl ready=%b cnt=%0d want 0/0", IN_READY, BYTE_COUNT); end
    step();
    RST = 1'b0;
    step();
    checks++; if (BUSY !== 1'b0 || IN_READY !== 1'b1) begin failures++; $display("FAIL rstmid_empty busy=%b ready=%b want 0/1", BUSY, IN_READY); end
    for (int c = 0; c < 10; c++) begin
      step();
      if (EN || STREAM_DONE || INITIALIZE) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL rstmid_quiet active_cycles=%0d want=0", bad); end
    checks++; if (BYTE_COUNT !== 16'd0) begin failures++; $display("FAIL rstmid_count got=%0d want=0", BYTE_COUNT); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full_fifo();
    test_hold_mid();
    test_reset_mid_feed();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
